// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply or restoring divide on operand magnitudes,
// then one sign-fix cycle. Divide-by-zero and signed overflow finish on the start edge.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  input  logic            stall_cache,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            stall_md
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]        op;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   b_mag;
  logic [2*XLEN-1:0] acc;
  logic              neg_hi;
  logic              neg_lo;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic              div_zero, div_ovf, fast;
  logic [XLEN-1:0]   fast_res;

  // Start-edge decode: magnitudes, sign flags and the single-cycle special cases.
  always_comb begin
    a_signed = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    b_signed = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = a_signed && op_a[XLEN-1];
    b_neg    = b_signed && op_b[XLEN-1];
    a_abs    = a_neg ? -op_a : op_a;
    b_abs    = b_neg ? -op_b : op_b;
    div_zero = funct3[2] && (op_b == '0);
    div_ovf  = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
               (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    fast     = div_zero || div_ovf;
    fast_res = '0;
    if (div_zero)
      fast_res = funct3[1] ? op_a : '1;
    else if (div_ovf)
      fast_res = funct3[1] ? '0 : op_a;
  end

  logic [XLEN-1:0]   mul_add;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] acc_step;

  // acc holds {hi, lo}: product for multiply, {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_add   = acc[0] ? b_mag : '0;
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mul_add};
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, b_mag};
    if (op[2]) begin
      if (div_diff[XLEN])
        acc_step = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else
        acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = neg_hi ? -acc : acc;
    quo_fix  = neg_hi ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = neg_lo ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else if (!stall_cache) begin
      case (state)
        IDLE:    if (start) state_nxt = fast ? DONE : CALC;
        CALC:    if (cnt == CNT_W'(XLEN-1)) state_nxt = FIX;
        FIX:     state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // The M-op and its successor advance together with done, so DONE itself does not stall.
  always_comb begin
    done     = (state == DONE);
    stall_md = ((state == IDLE) && start && !fast) || (state == CALC) || (state == FIX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op     <= '0;
      cnt    <= '0;
      b_mag  <= '0;
      acc    <= '0;
      neg_hi <= 1'b0;
      neg_lo <= 1'b0;
      result <= '0;
    end else if (!flush && !stall_cache) begin
      case (state)
        IDLE: begin
          if (start) begin
            op     <= funct3;
            cnt    <= '0;
            b_mag  <= b_abs;
            acc    <= {{XLEN{1'b0}}, a_abs};
            neg_hi <= a_neg ^ b_neg;
            neg_lo <= a_neg;
            if (fast)
              result <= fast_res;
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
        FIX: result <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, stall window, results, fast paths, flush, cache stall, reset.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        stall_cache;
  logic [31:0] result;
  logic        done;
  logic        stall_md;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .funct3      (funct3),
    .op_a        (op_a),
    .op_b        (op_b),
    .flush       (flush),
    .stall_cache (stall_cache),
    .result      (result),
    .done        (done),
    .stall_md    (stall_md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // lat counts edges after the start edge until done is seen; sc counts cycles with stall_md high.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input int exp_sc,
                        input int stall_at, input int poke_at);
    int lat;
    int sc;
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    #1 chk({tag, "_stall0"}, {31'b0, stall_md}, 32'(exp_lat != 0));
    @(negedge clk);
    start = 1'b0; op_a = 32'hDEADBEEF; op_b = 32'h0;
    lat = 0; sc = 0;
    while (!done && lat < 100) begin
      if (stall_md) sc++;
      if (lat == poke_at) begin start = 1'b1; funct3 = 3'b000; end
      else start = 1'b0;
      if (lat == stall_at) stall_cache = 1'b1;
      else if (lat == stall_at + 4) stall_cache = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0; stall_cache = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_stallcnt"}, 32'(sc), 32'(exp_sc));
    chk({tag, "_res"}, result, exp_res);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] prev;
    logic        seen;
    rst_n = 1'b0; start = 1'b0; funct3 = 3'b000; op_a = '0; op_b = '0;
    flush = 1'b0; stall_cache = 1'b0;
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_stall", {31'b0, stall_md}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 33, -1, -1);
    run_op("mulh",   3'b001, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33, 33, -1, -1);
    run_op("mulhsu", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 33, -1, -1);
    run_op("mulhu",  3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 33, 33, -1, -1);
    run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 33, -1, -1);
    run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 33, -1, -1);
    run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       33, 33, -1, 5);
    run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        33, 33, -1, -1);

    run_op("div0",   3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 0, 0, -1, -1);
    run_op("divu0",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 0, 0, -1, -1);
    run_op("remu0",  3'b111, 32'd5,        32'd0,        32'd5,        0, 0, -1, -1);
    run_op("rem0",   3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 0, 0, -1, -1);
    run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, -1, -1);
    run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0, 0, -1, -1);

    run_op("div_cstall", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 37, 37, 10, -1);
    run_op("remu_last",  3'b111, 32'd100,      32'd7, 32'd2,        33, 33, -1, -1);

    // Flush partway through a divide: no done, result untouched.
    prev = result;
    @(negedge clk); start = 1'b1; funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    #1;
    chk("flush_stall", {31'b0, stall_md}, 32'd0);
    chk("flush_done", {31'b0, done}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("flush_nodone", {31'b0, seen}, 32'd0);
    chk("flush_result", result, prev);

    // Asynchronous reset mid-multiply.
    @(negedge clk); start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_result", result, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_stall", {31'b0, stall_md}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op("mul_after_rst", 3'b000, 32'd3, 32'd5, 32'd15, 33, 33, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
